mac_kxk_acc: RTL and testbench
==============================

MAC_KXK_ACC -- requirements
Module: mac_kxk_acc

Interface
REQ-001 Parameter DATA_W, default 8: width of each pixel and weight element.
REQ-002 Parameter K, default 5: kernel edge; K*K multiply lanes.
REQ-003 Parameter ACC_W, default 24: output width.
REQ-004 Parameter CH_W, default 8: width of channel-count config.
REQ-005 clk  in  1: single clock; all state on rising edge.
REQ-006 rst  in  1: reset, asynchronous, active-high.
REQ-007 in_valid  in  1: one kernel window (beat) presented this cycle.
REQ-008 in_data  in  DATA_W*K*K: pixel window; element j=row*K+col at bits [DATA_W*(j+1)-1 : DATA_W*j].
REQ-009 in_weight  in  DATA_W*K*K: weights, same packing as in_data.
REQ-010 cfg_signed  in  1: 1 = two's-complement operands, 0 = unsigned.
REQ-011 cfg_nch  in  CH_W: beats (input channels) per output; 0 treated as 1.
REQ-012 out_valid  out  1: single-cycle pulse, one per completed group.
REQ-013 out_data  out  ACC_W: saturated group sum.
REQ-014 out_sat  out  1: out_data was clipped; valid with out_valid.
REQ-015 busy  out  1: a group is partially accumulated.

Function
REQ-016 No backpressure; every in_valid beat SHALL be accepted.
REQ-017 Group start = first beat with ch_cnt==0; cfg_signed and cfg_nch SHALL be latched there and ignored until group end.
REQ-018 ch_cnt SHALL increment per accepted beat and wrap to 0 on the beat where ch_cnt==nch-1 (last beat).
REQ-019 Stage 1: all K*K products SHALL be registered in the cycle after the beat, full 2*DATA_W width, sign per latched mode.
REQ-020 Stage 2: sum of K*K products SHALL be registered, width 2*DATA_W+clog2(K*K), no truncation.
REQ-021 Stage 3: accumulator, width 2*DATA_W+clog2(K*K)+CH_W; first beat of group SHALL load (not add), later beats add.
REQ-022 Latency: beat at cycle t -> its contribution in accumulator at t+3; last beat at t -> out_valid high in cycle t+3 only.
REQ-023 Idle cycles between beats of a group SHALL be allowed; pipeline stages advance only with their valid bit, accumulator holds otherwise.
REQ-024 Back-to-back groups SHALL need no idle cycles; new group's first beat never adds to previous sum.
REQ-025 Saturation: signed mode clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned clamps to [0, 2^ACC_W-1]; out_sat=1 iff clamped.
REQ-026 out_data/out_sat SHALL hold last value between pulses.
REQ-027 busy SHALL be registered: 1 from cycle after a non-last first beat until cycle after last beat; 0 for nch=1 groups.

Reset
REQ-028 rst SHALL clear immediately: out_valid=0, out_data=0, out_sat=0, busy=0, ch_cnt=0, all stage valids=0, accumulator=0.
REQ-029 rst mid-group SHALL discard partial sum and in-flight beats; no out_valid for that group.
REQ-030 First beat after rst deassertion SHALL start a new group.

Verification
REQ-031 Unsigned, nch=1, all data=1, weight=2 -> out_valid at t+3, out_data=50, out_sat=0.
REQ-032 Signed, nch=3, data=0xFF (-1), weight=3, three consecutive beats -> one pulse 3 cycles after third beat, out_data=0xFFFF1F (-225), busy high during group.
REQ-033 ACC_W=16, unsigned, nch=2, data=255, weight=255 -> out_data=0xFFFF, out_sat=1.
REQ-034 nch=2, beats separated by 4 idle cycles, data=1 weight=1 -> single pulse at 2nd beat+3, out_data=50.
REQ-035 nch=4, two beats, rst pulse -> no out_valid, outputs 0; then nch=1 data=1 weight=1 -> out_data=25.
REQ-036 nch=1, consecutive beats data=1 then data=2 (weight=1) -> pulses in consecutive cycles, out_data=25 then 50; cfg_nch change mid-group has no effect.

Source files
------------

// File: rtl/mac_kxk_acc_if.sv
// Beat/config/result bundle for the KxK multiply-accumulate block.
// The master drives windows and config; the slave returns group sums.
interface mac_kxk_acc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 5,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CH_W   = 8
);
    logic                     in_valid;
    logic [DATA_W*K*K-1:0]    in_data;
    logic [DATA_W*K*K-1:0]    in_weight;
    logic                     cfg_signed;
    logic [CH_W-1:0]          cfg_nch;
    logic                     out_valid;
    logic [ACC_W-1:0]         out_data;
    logic                     out_sat;
    logic                     busy;

    modport master (
        output in_valid, in_data, in_weight, cfg_signed, cfg_nch,
        input  out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_data, in_weight, cfg_signed, cfg_nch,
        output out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/mac_kxk_acc.sv
// KxK dot product per beat, summed over a group of cfg_nch beats, saturated to ACC_W.
// Pipeline: products -> adder tree -> accumulator/saturation, three cycles beat to result.
module mac_kxk_acc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 5,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CH_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    mac_kxk_acc_if.slave    bus_io
);
    localparam int unsigned NL = K * K;
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = PW + $clog2(NL);
    localparam int unsigned AW = SW + CH_W;
    localparam int unsigned EW = ((AW > ACC_W) ? AW : ACC_W) + 1;

    localparam logic [EW-1:0] S_MAX = EW'((64'd1 << (ACC_W - 1)) - 64'd1);
    localparam logic [EW-1:0] S_MIN = ~S_MAX;
    localparam logic [EW-1:0] U_MAX = EW'((64'd1 << ACC_W) - 64'd1);

    function automatic logic [PW-1:0] ext_p(input logic [DATA_W-1:0] v, input logic sgn);
        return {{DATA_W{sgn & v[DATA_W-1]}}, v};
    endfunction

    function automatic logic [SW-1:0] ext_s(input logic [PW-1:0] v, input logic sgn);
        return {{(SW - PW){sgn & v[PW-1]}}, v};
    endfunction

    function automatic logic [AW-1:0] ext_a(input logic [SW-1:0] v, input logic sgn);
        return {{(AW - SW){sgn & v[SW-1]}}, v};
    endfunction

    function automatic logic [EW-1:0] ext_e(input logic [AW-1:0] v, input logic sgn);
        return {{(EW - AW){sgn & v[AW-1]}}, v};
    endfunction

    // group bookkeeping
    logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
    logic [CH_W-1:0] nch_q, nch_d;
    logic            sgn_q, sgn_d;
    logic            busy_q, busy_d;
    logic            first_c, last_c, sgn_c;
    logic [CH_W-1:0] nch_c;

    // pipeline stages
    logic            s1_vld_q, s1_first_q, s1_last_q, s1_sgn_q;
    logic [PW-1:0]   prod_q [NL];
    logic [PW-1:0]   prod_d [NL];
    logic            s2_vld_q, s2_first_q, s2_last_q, s2_sgn_q;
    logic [SW-1:0]   sum_q, sum_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   sum_a_c;
    logic [EW-1:0]   acc_e_c;
    logic            out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic            out_sat_q, out_sat_d;

    // Config is taken live on a group's first beat, from the latched copy afterwards.
    always_comb begin
        ch_cnt_d = ch_cnt_q;
        nch_d    = nch_q;
        sgn_d    = sgn_q;
        busy_d   = busy_q;
        first_c  = (ch_cnt_q == '0);
        nch_c    = first_c ? ((bus_io.cfg_nch == '0) ? CH_W'(1) : bus_io.cfg_nch) : nch_q;
        sgn_c    = first_c ? bus_io.cfg_signed : sgn_q;
        last_c   = (ch_cnt_q == (nch_c - CH_W'(1)));
        if (bus_io.in_valid) begin
            nch_d    = nch_c;
            sgn_d    = sgn_c;
            ch_cnt_d = last_c ? '0 : (ch_cnt_q + CH_W'(1));
            busy_d   = !last_c;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NL; j++) begin
            prod_d[j] = ext_p(bus_io.in_data[DATA_W*j +: DATA_W], sgn_c)
                      * ext_p(bus_io.in_weight[DATA_W*j +: DATA_W], sgn_c);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned j = 0; j < NL; j++) begin
            sum_d = sum_d + ext_s(prod_q[j], s1_sgn_q);
        end
    end

    // Accumulate, then clamp the running total when the group closes.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        sum_a_c     = ext_a(sum_q, s2_sgn_q);
        if (s2_vld_q) begin
            acc_d = s2_first_q ? sum_a_c : (acc_q + sum_a_c);
        end
        acc_e_c = ext_e(acc_d, s2_sgn_q);
        if (s2_vld_q && s2_last_q) begin
            out_valid_d = 1'b1;
            out_sat_d   = 1'b0;
            out_data_d  = ACC_W'(acc_e_c);
            if (s2_sgn_q) begin
                if ($signed(acc_e_c) > $signed(S_MAX)) begin
                    out_data_d = ACC_W'(S_MAX);
                    out_sat_d  = 1'b1;
                end else if ($signed(acc_e_c) < $signed(S_MIN)) begin
                    out_data_d = ACC_W'(S_MIN);
                    out_sat_d  = 1'b1;
                end
            end else if (acc_e_c > U_MAX) begin
                out_data_d = ACC_W'(U_MAX);
                out_sat_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q <= '0;
            nch_q    <= '0;
            sgn_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
            nch_q    <= nch_d;
            sgn_q    <= sgn_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sgn_q   <= 1'b0;
            prod_q     <= '{default: '0};
        end else begin
            s1_vld_q <= bus_io.in_valid;
            if (bus_io.in_valid) begin
                s1_first_q <= first_c;
                s1_last_q  <= last_c;
                s1_sgn_q   <= sgn_c;
                prod_q     <= prod_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sgn_q   <= 1'b0;
            sum_q      <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
                s2_sgn_q   <= s1_sgn_q;
                sum_q      <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_sat   = out_sat_q;
    assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_mac_kxk_acc.sv
// Self-checking bench: two instances (ACC_W 24 and 16) fed identical beats, a cycle-level
// reference model of group sums, a table of directed groups and a randomized phase.
module tb_mac_kxk_acc;
    localparam int DW = 8;
    localparam int KK = 5;
    localparam int CW = 8;
    localparam int BW = DW * KK * KK;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [BW-1:0] in_data, in_weight;
    logic          cfg_signed;
    logic [CW-1:0] cfg_nch;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mac_kxk_acc_if #(.DATA_W(DW), .K(KK), .ACC_W(24), .CH_W(CW)) if24 ();
    mac_kxk_acc_if #(.DATA_W(DW), .K(KK), .ACC_W(16), .CH_W(CW)) if16 ();

    assign if24.in_valid   = in_valid;
    assign if24.in_data    = in_data;
    assign if24.in_weight  = in_weight;
    assign if24.cfg_signed = cfg_signed;
    assign if24.cfg_nch    = cfg_nch;
    assign if16.in_valid   = in_valid;
    assign if16.in_data    = in_data;
    assign if16.in_weight  = in_weight;
    assign if16.cfg_signed = cfg_signed;
    assign if16.cfg_nch    = cfg_nch;

    mac_kxk_acc #(.DATA_W(DW), .K(KK), .ACC_W(24), .CH_W(CW)) dut24 (
        .clk(clk), .rst(rst), .bus_io(if24.slave));
    mac_kxk_acc #(.DATA_W(DW), .K(KK), .ACC_W(16), .CH_W(CW)) dut16 (
        .clk(clk), .rst(rst), .bus_io(if16.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint dot(input logic [BW-1:0] d, input logic [BW-1:0] w, input bit sgn);
        longint s = 0;
        logic [7:0] a, b;
        for (int j = 0; j < KK * KK; j++) begin
            a = d[8*j +: 8];
            b = w[8*j +: 8];
            if (sgn) s += longint'($signed(a)) * longint'($signed(b));
            else     s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic longint lim_hi(input int w, input bit sgn);
        return sgn ? ((longint'(1) <<< (w - 1)) - 1) : ((longint'(1) <<< w) - 1);
    endfunction

    function automatic longint lim_lo(input int w, input bit sgn);
        return sgn ? -(longint'(1) <<< (w - 1)) : longint'(0);
    endfunction

    function automatic longint sat_val(input longint v, input int w, input bit sgn);
        longint r;
        r = (v > lim_hi(w, sgn)) ? lim_hi(w, sgn) : (v < lim_lo(w, sgn)) ? lim_lo(w, sgn) : v;
        return r & ((longint'(1) <<< w) - 1);
    endfunction

    function automatic longint sat_flag(input longint v, input int w, input bit sgn);
        return longint'((v > lim_hi(w, sgn)) || (v < lim_lo(w, sgn)));
    endfunction

    typedef struct {
        int     due;
        longint v;
        bit     sgn;
    } ev_t;

    ev_t    evq[$];
    int     cnt_m = 0, nch_m = 1;
    bit     sgn_m = 1'b0, busy_m = 1'b0;
    longint acc_m = 0;
    longint ld24 = 0, ls24 = 0, ld16 = 0, ls16 = 0;

    // Groups tracked as plain sums; a completed group's result is due 3 cycles after its last beat.
    always @(posedge clk) begin
        ev_t e;
        cyc = cyc + 1;
        if (rst) begin
            cnt_m  = 0;
            busy_m = 1'b0;
            evq.delete();
            ld24 = 0; ls24 = 0; ld16 = 0; ls16 = 0;
        end else if (in_valid) begin
            if (cnt_m == 0) begin
                nch_m = (cfg_nch == 0) ? 1 : int'(cfg_nch);
                sgn_m = cfg_signed;
                acc_m = 0;
            end
            acc_m += dot(in_data, in_weight, sgn_m);
            cnt_m++;
            if (cnt_m == nch_m) begin
                e.due = cyc + 2;
                e.v   = acc_m;
                e.sgn = sgn_m;
                evq.push_back(e);
                cnt_m = 0;
            end
            busy_m = (cnt_m != 0);
        end
    end

    always @(negedge clk) begin
        ev_t e;
        bit  ev;
        if (rst) begin
            chk("rst_valid24", longint'(if24.out_valid), 0);
            chk("rst_data24",  longint'(if24.out_data),  0);
            chk("rst_sat24",   longint'(if24.out_sat),   0);
            chk("rst_busy24",  longint'(if24.busy),      0);
            chk("rst_valid16", longint'(if16.out_valid), 0);
            chk("rst_data16",  longint'(if16.out_data),  0);
        end else begin
            ev = (evq.size() > 0) && (evq[0].due == cyc);
            if (ev) begin
                e    = evq.pop_front();
                ld24 = sat_val(e.v, 24, e.sgn);
                ls24 = sat_flag(e.v, 24, e.sgn);
                ld16 = sat_val(e.v, 16, e.sgn);
                ls16 = sat_flag(e.v, 16, e.sgn);
            end
            chk("m_valid24", longint'(if24.out_valid), longint'(ev));
            chk("m_data24",  longint'(if24.out_data),  ld24);
            chk("m_sat24",   longint'(if24.out_sat),   ls24);
            chk("m_busy24",  longint'(if24.busy),      longint'(busy_m));
            chk("m_valid16", longint'(if16.out_valid), longint'(ev));
            chk("m_data16",  longint'(if16.out_data),  ld16);
            chk("m_sat16",   longint'(if16.out_sat),   ls16);
            chk("m_busy16",  longint'(if16.busy),      longint'(busy_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input bit sgn, input int nch, input logic [7:0] d, input logic [7:0] w);
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        cfg_signed = sgn;
        cfg_nch    = 8'(nch);
        in_data    = {25{d}};
        in_weight  = {25{w}};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Waits (bounded) for the pulse after a just-driven last beat; expects it 3 cycles later.
    task automatic wait_out(input string name, input longint e24, input longint s24,
                            input longint e16, input longint s16);
        int got = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (if24.out_valid) begin
                got = k;
                break;
            end
        end
        chk({name, "_lat"}, longint'(got), 3);
        if (got != 0) begin
            chk({name, "_d24"}, longint'(if24.out_data), e24);
            chk({name, "_s24"}, longint'(if24.out_sat),  s24);
            chk({name, "_d16"}, longint'(if16.out_data), e16);
            chk({name, "_s16"}, longint'(if16.out_sat),  s16);
        end
    endtask

    typedef struct {
        string      name;
        bit         sgn;
        int         nch;
        logic [7:0] d;
        logic [7:0] w;
        int         gap;
        longint     e24;
        longint     s24;
        longint     e16;
        longint     s16;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] rd, rw;
        int nb;

        tbl[0] = '{"u_n1_basic",   1'b0, 1,  8'h01, 8'h02, 0, 64'd50,      0, 64'd50,     0};
        tbl[1] = '{"s_n3_neg",     1'b1, 3,  8'hFF, 8'h03, 0, 64'hFFFF1F,  0, 64'hFF1F,   0};
        tbl[2] = '{"u_n2_max",     1'b0, 2,  8'hFF, 8'hFF, 0, 64'h319C32,  0, 64'hFFFF,   1};
        tbl[3] = '{"u_n2_gap4",    1'b0, 2,  8'h01, 8'h01, 4, 64'd50,      0, 64'd50,     0};
        tbl[4] = '{"s_n1_minmin",  1'b1, 1,  8'h80, 8'h80, 0, 64'h064000,  0, 64'h7FFF,   1};
        tbl[5] = '{"s_n1_minmax",  1'b1, 1,  8'h80, 8'h7F, 0, 64'hF9CC80,  0, 64'h8000,   1};
        tbl[6] = '{"s_n0_as_1",    1'b1, 0,  8'h02, 8'h03, 1, 64'h96,      0, 64'h96,     0};
        tbl[7] = '{"s_n21_possat", 1'b1, 21, 8'h80, 8'h80, 0, 64'h7FFFFF,  1, 64'h7FFF,   1};
        tbl[8] = '{"u_n11_sat",    1'b0, 11, 8'hFF, 8'hFF, 0, 64'hFFFFFF,  1, 64'hFFFF,   1};

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_weight  = '0;
        cfg_signed = 1'b0;
        cfg_nch    = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // directed groups
        for (int i = 0; i < 9; i++) begin
            nb = (tbl[i].nch == 0) ? 1 : tbl[i].nch;
            for (int b = 0; b < nb; b++) begin
                beat(tbl[i].sgn, tbl[i].nch, tbl[i].d, tbl[i].w);
                if (b < nb - 1) idle(tbl[i].gap);
            end
            wait_out(tbl[i].name, tbl[i].e24, tbl[i].s24, tbl[i].e16, tbl[i].s16);
            idle(1);
        end

        // back-to-back single-beat groups
        beat(1'b0, 1, 8'h01, 8'h01);
        beat(1'b0, 1, 8'h02, 8'h01);
        idle(2);
        chk("b2b_v1", longint'(if24.out_valid), 1);
        chk("b2b_d1", longint'(if24.out_data), 25);
        idle(1);
        chk("b2b_v2", longint'(if24.out_valid), 1);
        chk("b2b_d2", longint'(if24.out_data), 50);
        idle(2);

        // config changes after the first beat must not alter the group
        beat(1'b1, 3, 8'h01, 8'h01);
        beat(1'b0, 1, 8'h01, 8'h01);
        beat(1'b0, 7, 8'h01, 8'h01);
        wait_out("nch_latch", 75, 0, 75, 0);
        idle(2);

        // reset in the middle of a group
        beat(1'b0, 4, 8'h01, 8'h01);
        beat(1'b0, 4, 8'h01, 8'h01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("rst_mid_valid", longint'(if24.out_valid), 0);
            chk("rst_mid_data",  longint'(if24.out_data),  0);
            chk("rst_mid_busy",  longint'(if24.busy),      0);
        end
        beat(1'b0, 1, 8'h01, 8'h01);
        wait_out("after_rst", 25, 0, 25, 0);
        idle(2);

        // randomized beats, config churn and occasional resets against the model
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 149) == 0) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                for (int j = 0; j < KK * KK; j++) begin
                    rd[8*j +: 8] = 8'($urandom);
                    rw[8*j +: 8] = 8'($urandom);
                end
                in_valid   = ($urandom_range(0, 3) != 0);
                in_data    = rd;
                in_weight  = rw;
                cfg_signed = 1'($urandom);
                cfg_nch    = 8'($urandom_range(0, 4));
            end
        end
        idle(8);
        chk("drain_empty", longint'(evq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
